elevator_ctrl: RTL and testbench
================================

# elevator_ctrl

- Travel scheduler that sits directly upstream of the floor counter. It latches floor calls and reads back the current floor, the `count` value from the counter.
- It drives the counter's `en` and `up_down` inputs so the car moves one floor per travel interval, and it controls the door.
- Direction policy is SCAN: keep going while calls remain ahead, reverse only when none do.
- It never commands the counter past 0 or 9, so the counter's modulo wrap path is never exercised.

## Interface

- `NUM_FLOORS`, 10: floors 0..NUM_FLOORS-1; must be ≤10 (BCD floor).
- `TRAVEL_CYCLES`, 8: clock cycles per floor of travel; must be ≥2.
- `DOOR_CYCLES`, 6: cycles the door stays open; must be ≥1.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-low; sampled on `clk` rising edge.
- `req` in NUM_FLOORS: call buttons, one bit per floor; level-sampled every cycle.
- `floor` in 4: current floor, from the counter's `count`.
- `cnt_en` out 1: counter step enable; one-cycle pulse.
- `cnt_up_down` out 1: 1 = up, 0 = down; equals the current direction register.
- `door_open` out 1: high while in DOOR.
- `moving` out 1: high while in MOVE.
- `pending` out NUM_FLOORS: latched outstanding calls.

## Operation

- **Reset** (`reset`=0 at an edge):
  - state IDLE, pending=0, timer=0.
  - cnt_en=0, cnt_up_down=1, door_open=0, moving=0.
  - Reset mid-travel or mid-door aborts immediately; no step pulse is issued.
- **Latching:** each cycle, pending <= (pending | req) & ~clr, where clr is the bit being served this cycle. A req bit for the floor being served in that same cycle is absorbed, not kept.
- **"Ahead" definition:** any pending bit above `floor` when direction is up, or below `floor` when direction is down.
- **IDLE:**
  - pending[floor]=1 → DOOR; clear that bit.
  - else any call ahead in the current direction → MOVE.
  - else any call behind → flip direction, then MOVE.
  - else stay in IDLE.
- **MOVE:**
  - Timer counts 0..TRAVEL_CYCLES-1.
  - At terminal count: cnt_en=1 for exactly one cycle and timer resets. The counter updates `floor` at the same edge.
  - The cycle after the pulse, the new `floor` is evaluated:
    - pending[floor]=1 → DOOR; clear that bit.
    - no call ahead → IDLE.
    - else keep moving.
- **DOOR:**
  - Timer counts DOOR_CYCLES.
  - req at the current floor during DOOR restarts the door timer and is not latched.
  - At expiry: call ahead → MOVE; call behind → flip direction and MOVE; none → IDLE.
- **Bounds:** cnt_en is never asserted with cnt_up_down=1 at floor NUM_FLOORS-1, or with cnt_up_down=0 at floor 0. This is an assertion target.
- **Direction changes:** only in IDLE, or at DOOR expiry; never in MOVE.

## Timing

- Call to first step pulse, from IDLE with a call ahead: 1 cycle to enter MOVE, then TRAVEL_CYCLES → pulse at cycle TRAVEL_CYCLES+1 after req.
- Step pulse to reaction on the new floor: 1 cycle (DOOR entered on the edge after the pulse edge).
- Door open duration: DOOR_CYCLES cycles of door_open=1, absent restarts.
- Outputs are registered; no combinational path from req to any output.

## Configuration

- `ELEVATOR_EMERG_EN` defined: adds input port `emerg` (1 bit, active-high).
  - While asserted: pending is forced to 0 and new req is ignored. Direction becomes down at the next IDLE/DOOR decision point; a MOVE in progress completes its current floor step first.
  - The car travels to floor 0, enters DOOR, and holds door_open=1 indefinitely.
  - On deassertion: the door timer runs its normal DOOR_CYCLES, then IDLE.
- Not defined: no `emerg` port, no emergency logic.

## Structure

- Shared package `rideup_pkg`:
  - state enum (IDLE, MOVE, DOOR).
  - `FLOOR_W`=4.
  - default constants for NUM_FLOORS, TRAVEL_CYCLES, DOOR_CYCLES.
- Sub-module `ride_timer`:
  - load/clear, count-enable, parameterised terminal count, `done` pulse.
  - Shared by the MOVE and DOOR timing.
- The ahead/behind detection is combinational mask logic inside elevator_ctrl.

## Test plan

- Reset, then no req for 20 cycles → state IDLE, all outputs 0 except cnt_up_down=1, no cnt_en pulses.
- Floor 0, req[3] pulsed one cycle, TRAVEL_CYCLES=8 → exactly 3 cnt_en pulses with cnt_up_down=1, at cycles 9, 18, 27. door_open=1 for 6 cycles at floor 3, then IDLE; pending=0.
- Floor 5, req[7] and req[2] together → serve 7 first (2 up pulses, door), then flip: 5 down pulses to floor 2, door.
- Floor 9 with only req[9], then floor 0 with only req[0] → door opens and no cnt_en in both cases. Bounds assertion never fires in a 10k-cycle random-req run.
- Door open at floor 4, req[4] reasserted at door cycle 4 → door_open stays high for 6 more cycles from the restart.
- Reset asserted mid-MOVE, one cycle before the terminal count → no cnt_en pulse, pending=0, IDLE. With `ELEVATOR_EMERG_EN`: emerg at floor 6 moving up → finishes step to 7, reverses, steps down to 0, door held until emerg drops.

Source files
------------

// File: rtl/rideup_pkg.sv
// Shared types and default constants for the elevator travel scheduler.
package rideup_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_e;

  localparam int FLOOR_W           = 4;
  localparam int DEF_NUM_FLOORS    = 10;
  localparam int DEF_TRAVEL_CYCLES = 8;
  localparam int DEF_DOOR_CYCLES   = 6;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ride_timer.sv
// Wrapping interval timer shared by floor travel and door hold timing.
// done is high while the count sits at term; an enabled count at term wraps to 0.
module ride_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         done
);

  logic [W-1:0] cnt_q;

  assign done = (cnt_q == term);

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= done ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/elevator_ctrl.sv
// SCAN travel scheduler driving an external BCD floor counter and the car door.
// Define ELEVATOR_EMERG_EN to add the emerg input (recall to floor 0, door held open).
module elevator_ctrl
  import rideup_pkg::*;
#(
  parameter int NUM_FLOORS    = DEF_NUM_FLOORS,
  parameter int TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
  parameter int DOOR_CYCLES   = DEF_DOOR_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef ELEVATOR_EMERG_EN
  input  logic                  emerg,
`endif
  input  logic [NUM_FLOORS-1:0] req,
  input  logic [FLOOR_W-1:0]    floor,
  output logic                  cnt_en,
  output logic                  cnt_up_down,
  output logic                  door_open,
  output logic                  moving,
  output logic [NUM_FLOORS-1:0] pending,
  output state_e                dbg_state
);

  localparam int TW = $clog2(max_int(TRAVEL_CYCLES, DOOR_CYCLES));

  state_e                  state_q, state_d;
  logic                    dir_q, dir_d;
  logic                    arrive_q, arrive_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d, clr;
  logic [NUM_FLOORS-1:0]   here_m, above_m, below_m;
  logic                    here_hit, above_any, below_any, ahead, behind;
  logic                    at_bottom, emerg_w, step;
  logic                    tmr_clr, tmr_en, tmr_done;
  logic [TW-1:0]           tmr_term;

`ifdef ELEVATOR_EMERG_EN
  assign emerg_w = emerg;
`else
  assign emerg_w = 1'b0;
`endif

  always_comb begin
    here_m  = '0;
    above_m = '0;
    below_m = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      here_m[i]  = (FLOOR_W'(i) == floor);
      above_m[i] = (FLOOR_W'(i) > floor);
      below_m[i] = (FLOOR_W'(i) < floor);
    end
  end

  assign here_hit  = |(pending_q & here_m);
  assign above_any = |(pending_q & above_m);
  assign below_any = |(pending_q & below_m);
  assign ahead     = dir_q ? above_any : below_any;
  assign behind    = dir_q ? below_any : above_any;
  assign at_bottom = (floor == '0);

  // Terminal count depends only on the registered state, keeping done loop-free.
  assign tmr_term = (state_q == DOOR) ? TW'(DOOR_CYCLES - 1) : TW'(TRAVEL_CYCLES - 1);

  ride_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .term  (tmr_term),
    .done  (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    arrive_d = arrive_q;
    clr      = '0;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;
    step     = 1'b0;
    unique case (state_q)
      IDLE: begin
        tmr_clr = 1'b1;
        if (emerg_w) begin
          if (at_bottom) begin
            state_d = DOOR;
          end else begin
            dir_d    = 1'b0;
            arrive_d = 1'b0;
            state_d  = MOVE;
          end
        end else if (here_hit) begin
          clr     = here_m;
          state_d = DOOR;
        end else if (ahead) begin
          arrive_d = 1'b0;
          state_d  = MOVE;
        end else if (behind) begin
          dir_d    = ~dir_q;
          arrive_d = 1'b0;
          state_d  = MOVE;
        end
      end
      MOVE: begin
        if (!arrive_q) begin
          tmr_en = 1'b1;
          if (tmr_done) begin
            step     = 1'b1;
            arrive_d = 1'b1;
          end
        end else begin
          // One cycle after the step the counter shows the new floor.
          arrive_d = 1'b0;
          tmr_clr  = 1'b1;
          if (emerg_w) begin
            if (at_bottom)  state_d = DOOR;
            else if (dir_q) state_d = IDLE;
          end else if (here_hit) begin
            clr     = here_m;
            state_d = DOOR;
          end else if (!ahead) begin
            state_d = IDLE;
          end
        end
      end
      DOOR: begin
        clr = here_m;
        if (emerg_w && at_bottom) begin
          tmr_clr = 1'b1;
        end else if (!emerg_w && |(req & here_m)) begin
          tmr_clr = 1'b1;
        end else begin
          tmr_en = 1'b1;
          if (tmr_done) begin
            arrive_d = 1'b0;
            if (emerg_w) begin
              dir_d   = 1'b0;
              state_d = MOVE;
            end else if (ahead) begin
              state_d = MOVE;
            end else if (behind) begin
              dir_d   = ~dir_q;
              state_d = MOVE;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pending_d = emerg_w ? '0 : ((pending_q | req) & ~clr);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      dir_q     <= 1'b1;
      arrive_q  <= 1'b0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      arrive_q  <= arrive_d;
      pending_q <= pending_d;
    end
  end

  assign cnt_en      = step;
  assign cnt_up_down = dir_q;
  assign door_open   = (state_q == DOOR);
  assign moving      = (state_q == MOVE);
  assign pending     = pending_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl with a behavioural floor counter in the loop.
module tb_elevator_ctrl;
  import rideup_pkg::*;

  localparam int NF = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NF-1:0] req = '0;
  logic [3:0]    floor = 4'd0;
  logic          cnt_en, cnt_up_down, door_open, moving;
  logic [NF-1:0] pending;
  state_e        dbg_state;
`ifdef ELEVATOR_EMERG_EN
  logic          emerg = 1'b0;
`endif

  logic          load = 1'b0;
  logic [3:0]    load_val = 4'd0;
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_err = 0;
  int            pulse_cyc[$];
  logic          pulse_dir[$];
  logic [31:0]   exp_q[$];
  logic          exp_dir[$];
  int            door_cnt = 0;
  int            door_first = -1;
  int            door_last = -1;

  elevator_ctrl #(
    .NUM_FLOORS    (NF),
    .TRAVEL_CYCLES (8),
    .DOOR_CYCLES   (6)
  ) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef ELEVATOR_EMERG_EN
    .emerg       (emerg),
`endif
    .req         (req),
    .floor       (floor),
    .cnt_en      (cnt_en),
    .cnt_up_down (cnt_up_down),
    .door_open   (door_open),
    .moving      (moving),
    .pending     (pending),
    .dbg_state   (dbg_state)
  );

  // clock / counter model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load)        floor <= load_val;
    else if (cnt_en) floor <= cnt_up_down ? floor + 4'd1 : floor - 4'd1;
  end

  // monitor: step log, bounds, door occupancy
  always @(negedge clk) begin
    if (cnt_en) begin
      pulse_cyc.push_back(cyc);
      pulse_dir.push_back(cnt_up_down);
      n_cmp++;
      if ((cnt_up_down && floor == 4'(NF - 1)) || (!cnt_up_down && floor == 4'd0)) begin
        n_err++;
        $display("FAIL bounds: step at floor %0d dir %0b, required a step staying within 0..%0d",
                 floor, cnt_up_down, NF - 1);
      end
    end
    if (door_open) begin
      door_cnt++;
      door_last = cyc;
      if (door_first < 0) door_first = cyc;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    pulse_cyc.delete();
    pulse_dir.delete();
    exp_q.delete();
    exp_dir.delete();
    door_cnt   = 0;
    door_first = -1;
    door_last  = -1;
  endtask

  task automatic do_reset(input logic [3:0] f);
    @(negedge clk);
    reset    = 1'b0;
    load     = 1'b1;
    load_val = f;
    req      = '0;
    @(negedge clk);
    reset = 1'b1;
    load  = 1'b0;
    clear_logs();
  endtask

  task automatic pulse_req(input logic [NF-1:0] r, output int c0);
    req = r;
    c0  = cyc;
    @(negedge clk);
    req = '0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (!(dbg_state == IDLE && pending == '0) && k < budget) begin
      tick(1);
      k++;
    end
    n_cmp++;
    if (k >= budget) begin
      n_err++;
      $display("FAIL %s_idle_timeout: state %0d pending %b after %0d cycles, required IDLE with no calls",
               name, dbg_state, pending, budget);
    end
  endtask

  // scoreboard: observed steps against expected times and directions
  task automatic check_steps(input string name);
    n_cmp++;
    if (pulse_cyc.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL %s_step_count: got %0d, expected %0d", name, pulse_cyc.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (32'(pulse_cyc[i]) !== exp_q[i] || pulse_dir[i] !== exp_dir[i]) begin
          n_err++;
          $display("FAIL %s_step%0d: got cycle %0d dir %0b, expected cycle %0d dir %0b",
                   name, i, pulse_cyc[i], pulse_dir[i], exp_q[i], exp_dir[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset(4'd0);
    tick(20);
    n_cmp++;
    if (dbg_state !== IDLE) begin n_err++; $display("FAIL rst_state: got %0d, expected %0d", dbg_state, IDLE); end
    n_cmp++;
    if ({cnt_en, cnt_up_down, door_open, moving} !== 4'b0100) begin
      n_err++;
      $display("FAIL rst_outputs: got en/ud/door/mov %b, expected 0100", {cnt_en, cnt_up_down, door_open, moving});
    end
    n_cmp++;
    if (pending !== '0) begin n_err++; $display("FAIL rst_pending: got %b, expected 0", pending); end
    n_cmp++;
    if (pulse_cyc.size() !== 0 || door_cnt !== 0) begin
      n_err++;
      $display("FAIL rst_activity: got %0d steps %0d door cycles, expected 0 and 0", pulse_cyc.size(), door_cnt);
    end
  endtask

  task automatic test_single_call();
    int c0;
    do_reset(4'd0);
    pulse_req(10'b1 << 3, c0);
    wait_idle("single", 100);
    exp_q   = '{32'(c0 + 9), 32'(c0 + 18), 32'(c0 + 27)};
    exp_dir = '{1'b1, 1'b1, 1'b1};
    check_steps("single");
    n_cmp++;
    if (door_cnt !== 6 || door_first !== c0 + 29) begin
      n_err++;
      $display("FAIL single_door: got %0d cycles from %0d, expected 6 from %0d", door_cnt, door_first - c0, 29);
    end
    n_cmp++;
    if (floor !== 4'd3) begin n_err++; $display("FAIL single_floor: got %0d, expected 3", floor); end
  endtask

  task automatic test_scan();
    int c0;
    do_reset(4'd5);
    pulse_req((10'b1 << 7) | (10'b1 << 2), c0);
    wait_idle("scan", 200);
    exp_q   = '{32'(c0 + 9), 32'(c0 + 18), 32'(c0 + 33), 32'(c0 + 42),
                32'(c0 + 51), 32'(c0 + 60), 32'(c0 + 69)};
    exp_dir = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    check_steps("scan");
    n_cmp++;
    if (door_cnt !== 12 || door_last !== c0 + 76) begin
      n_err++;
      $display("FAIL scan_door: got %0d cycles ending %0d, expected 12 ending %0d", door_cnt, door_last - c0, 76);
    end
    n_cmp++;
    if (floor !== 4'd2 || cnt_up_down !== 1'b0) begin
      n_err++;
      $display("FAIL scan_end: got floor %0d dir %0b, expected floor 2 dir 0", floor, cnt_up_down);
    end
  endtask

  task automatic test_boundary();
    int c0;
    do_reset(4'd9);
    pulse_req(10'b1 << 9, c0);
    wait_idle("top", 50);
    n_cmp++;
    if (pulse_cyc.size() !== 0 || door_cnt !== 6 || door_first !== c0 + 2 || floor !== 4'd9) begin
      n_err++;
      $display("FAIL top_floor: got %0d steps %0d door cycles from %0d floor %0d, expected 0 6 2 9",
               pulse_cyc.size(), door_cnt, door_first - c0, floor);
    end
    do_reset(4'd0);
    pulse_req(10'b1, c0);
    wait_idle("bottom", 50);
    n_cmp++;
    if (pulse_cyc.size() !== 0 || door_cnt !== 6 || door_first !== c0 + 2 || floor !== 4'd0) begin
      n_err++;
      $display("FAIL bottom_floor: got %0d steps %0d door cycles from %0d floor %0d, expected 0 6 2 0",
               pulse_cyc.size(), door_cnt, door_first - c0, floor);
    end
  endtask

  task automatic test_door_restart();
    int c0;
    do_reset(4'd4);
    pulse_req(10'b1 << 4, c0);
    tick(4);
    n_cmp++;
    if (door_open !== 1'b1) begin n_err++; $display("FAIL restart_open: got %0b, expected 1", door_open); end
    req = 10'b1 << 4;
    tick(1);
    req = '0;
    n_cmp++;
    if (pending !== '0) begin n_err++; $display("FAIL restart_absorb: got %b, expected 0", pending); end
    wait_idle("restart", 50);
    n_cmp++;
    if (door_cnt !== 10 || door_last !== c0 + 11 || pulse_cyc.size() !== 0) begin
      n_err++;
      $display("FAIL restart_door: got %0d cycles ending %0d steps %0d, expected 10 ending 11 steps 0",
               door_cnt, door_last - c0, pulse_cyc.size());
    end
  endtask

  task automatic test_reset_mid_move();
    int c0;
    do_reset(4'd0);
    pulse_req(10'b1 << 5, c0);
    tick(7);
    n_cmp++;
    if (moving !== 1'b1) begin n_err++; $display("FAIL midrst_moving: got %0b, expected 1", moving); end
    reset = 1'b0;
    tick(1);
    n_cmp++;
    if (cnt_en !== 1'b0 || dbg_state !== IDLE || pending !== '0) begin
      n_err++;
      $display("FAIL midrst_abort: got en %0b state %0d pending %b, expected 0 IDLE 0", cnt_en, dbg_state, pending);
    end
    reset = 1'b1;
    tick(15);
    n_cmp++;
    if (pulse_cyc.size() !== 0 || floor !== 4'd0 || dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL midrst_after: got %0d steps floor %0d state %0d, expected 0 0 IDLE",
               pulse_cyc.size(), floor, dbg_state);
    end
  endtask

  task automatic test_random();
    do_reset(4'd0);
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 15) == 0) req = NF'(1) << $urandom_range(0, NF - 1);
      else                            req = '0;
      tick(1);
    end
    req = '0;
    wait_idle("random", 400);
    n_cmp++;
    if (pulse_cyc.size() == 0 || floor > 4'(NF - 1)) begin
      n_err++;
      $display("FAIL random_run: got %0d steps final floor %0d, expected some steps and floor <= %0d",
               pulse_cyc.size(), floor, NF - 1);
    end
  endtask

`ifdef ELEVATOR_EMERG_EN
  task automatic test_emerg();
    int c0;
    int e0;
    do_reset(4'd6);
    pulse_req(10'b1 << 9, c0);
    tick(4);
    emerg = 1'b1;
    tick(1);
    req = 10'b1 << 3;
    tick(1);
    req = '0;
    n_cmp++;
    if (pending !== '0) begin n_err++; $display("FAIL emerg_pending: got %b, expected 0", pending); end
    tick(93);
    exp_q   = '{32'(c0 + 9), 32'(c0 + 19), 32'(c0 + 28), 32'(c0 + 37),
                32'(c0 + 46), 32'(c0 + 55), 32'(c0 + 64), 32'(c0 + 73)};
    exp_dir = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    check_steps("emerg");
    n_cmp++;
    if (door_open !== 1'b1 || floor !== 4'd0 || door_first !== c0 + 75) begin
      n_err++;
      $display("FAIL emerg_hold: got door %0b floor %0d from %0d, expected 1 0 from 75",
               door_open, floor, door_first - c0);
    end
    e0 = cyc;
    emerg = 1'b0;
    tick(5);
    n_cmp++;
    if (door_open !== 1'b1) begin n_err++; $display("FAIL emerg_release_open: got %0b at +%0d, expected 1", door_open, cyc - e0); end
    tick(1);
    n_cmp++;
    if (door_open !== 1'b0 || dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL emerg_release_close: got door %0b state %0d, expected 0 IDLE", door_open, dbg_state);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_call();
    test_scan();
    test_boundary();
    test_door_restart();
    test_reset_mid_move();
`ifdef ELEVATOR_EMERG_EN
    test_emerg();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
